// File: rtl/ysyx_22050612_ifu_fetch.sv
// Instruction fetch stage: owns the architectural PC, issues one 8-byte read per
// instruction, and hands {inst, pc} to decode, honouring EXU redirects.
module ysyx_22050612_ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_next;
    logic [63:0] pc, pc_next;
    logic [63:0] req_pc, req_pc_next;
    logic        drop, drop_next;
    logic        valid_next;
    logic [31:0] inst_next;
    logic [63:0] opc_next;

    // Request channel is a pure function of registered state.
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {pc[63:3], 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= '0;
            drop      <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            req_pc    <= req_pc_next;
            drop      <= drop_next;
            out_valid <= valid_next;
            out_inst  <= inst_next;
            out_pc    <= opc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        drop_next   = drop;
        valid_next  = out_valid;
        inst_next   = out_inst;
        opc_next    = out_pc;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect_valid) pc_next = redirect_pc;
                if (mem_req_ready) begin
                    req_pc_next = pc;
                    state_next  = WAIT;
                    // A request already in flight to the old pc must be discarded.
                    if (redirect_valid) drop_next = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                    if (mem_resp_valid) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (mem_resp_valid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        inst_next  = req_pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
                        opc_next   = req_pc;
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                    state_next = REQ;
                end else if (out_ready) begin
                    pc_next    = out_pc + 64'd4;
                    valid_next = 1'b0;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
